// File: rtl/decode_stage_hs.sv
// decode_stage_hs: RV32I/RV32E decode stage with ID/EX pipeline register.
// Decodes InstrD (main decoder, ALU decoder, immediate extender), reads an
// NREGS-entry register file with optional write-through bypass and loads
// the ID/EX slot under valid/ready handshakes. It also handles branch
// flush, the load-use bubble and a sticky halt on an illegal instruction.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   ValidD/ReadyD     decode-side handshake; InstrD, PCD, PCPlus4D payload
//   RegWriteW/RDW/ResultW  writeback port into the register file
//   FlushE            taken branch: kill the slot and the current D beat
//   ValidE/ReadyE     execute-side handshake for the ID/EX slot
//   *E outputs        registered controls, operands, PCs, register indices
//   IllegalOp, Halted registered illegal flag of the slot, sticky halt
//   StallCnt          load-use bubble counter
//
// Optional feature: define DECODE_STALL_COUNT_EN to build the saturating
// StallCnt counter; otherwise StallCnt is tied to 0.
module decode_stage_hs #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned RF_BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ValidD,
  output logic            ReadyD,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            ValidE,
  input  logic            ReadyE,
  output logic            RegWriteE,
  output logic            ALUSrcE,
  output logic            MemWriteE,
  output logic            ResultSrcE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] ImmExt_E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      RD_E,
  output logic [4:0]      RS1_E,
  output logic [4:0]      RS2_E,
  output logic            IllegalOp,
  output logic            Halted,
  output logic [31:0]     StallCnt
);

  localparam int unsigned RAW = (NREGS == 16) ? 4 : 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic [4:0] rd_d;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rd_d   = InstrD[11:7];
  assign rs1_d  = InstrD[19:15];
  assign rs2_d  = InstrD[24:20];

  // RV32E only implements x0..x15; RV32I accepts every 5-bit index
  function automatic logic in_range(input logic [4:0] idx);
    return (NREGS != 16) || !idx[4];
  endfunction

  // Main decoder: controls, immediate format, ALU op class, fields used
  logic       reg_write_d;
  logic       alu_src_d;
  logic       mem_write_d;
  logic       result_src_d;
  logic       branch_d;
  logic [1:0] imm_src_d;
  logic [1:0] alu_op_d;
  logic       cu_illegal;
  logic       use_rs1;
  logic       use_rs2;
  logic       use_rd;

  always_comb begin
    reg_write_d  = 1'b0;
    alu_src_d    = 1'b0;
    mem_write_d  = 1'b0;
    result_src_d = 1'b0;
    branch_d     = 1'b0;
    imm_src_d    = 2'b00;
    alu_op_d     = 2'b00;
    cu_illegal   = 1'b0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    use_rd       = 1'b0;
    case (opcode)
      OP_LOAD: begin
        reg_write_d  = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = 1'b1;
        use_rs1      = 1'b1;
        use_rd       = 1'b1;
      end
      OP_STORE: begin
        alu_src_d   = 1'b1;
        mem_write_d = 1'b1;
        imm_src_d   = 2'b01;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
      end
      OP_REG: begin
        reg_write_d = 1'b1;
        alu_op_d    = 2'b10;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        use_rd      = 1'b1;
      end
      OP_IMM: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        alu_op_d    = 2'b10;
        use_rs1     = 1'b1;
        use_rd      = 1'b1;
      end
      OP_BRANCH: begin
        branch_d  = 1'b1;
        imm_src_d = 2'b10;
        alu_op_d  = 2'b01;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      default: cu_illegal = 1'b1;
    endcase
  end

  // ALU decoder; SUB only for register-register funct7[5]=1
  logic [2:0] alu_control_d;

  always_comb begin
    alu_control_d = ALU_ADD;
    case (alu_op_d)
      2'b00: alu_control_d = ALU_ADD;
      2'b01: alu_control_d = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_control_d = (opcode[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_d = ALU_SLT;
          3'b110:  alu_control_d = ALU_OR;
          3'b111:  alu_control_d = ALU_AND;
          default: alu_control_d = ALU_ADD;
        endcase
      end
    endcase
  end

  // Immediate extender (I, S, B formats)
  logic [XLEN-1:0] imm_ext_d;

  always_comb begin
    imm_ext_d = '0;
    case (imm_src_d)
      2'b00:   imm_ext_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      2'b01:   imm_ext_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10:   imm_ext_d = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                            InstrD[30:25], InstrD[11:8], 1'b0};
      default: imm_ext_d = '0;
    endcase
  end

  logic illegal_d;
  assign illegal_d = cu_illegal ||
                     (use_rs1 && !in_range(rs1_d)) ||
                     (use_rs2 && !in_range(rs2_d)) ||
                     (use_rd  && !in_range(rd_d));

  // Register file with write-through bypass
  logic [XLEN-1:0] rf [NREGS];
  logic            wr_en;
  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;

  assign wr_en = RegWriteW && (RDW != 5'd0) && in_range(RDW);

  function automatic logic [XLEN-1:0] rf_pick(input logic [4:0]      idx,
                                              input logic [XLEN-1:0] stored,
                                              input logic            we,
                                              input logic [4:0]      widx,
                                              input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] v;
    v = '0;
    if (idx != 5'd0 && in_range(idx)) begin
      if (RF_BYPASS != 0 && we && widx == idx) v = wdata;
      else                                     v = stored;
    end
    return v;
  endfunction

  assign rd1_d = rf_pick(rs1_d, rf[rs1_d[RAW-1:0]], wr_en, RDW, ResultW);
  assign rd2_d = rf_pick(rs2_d, rf[rs2_d[RAW-1:0]], wr_en, RDW, ResultW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[RAW'(i)] <= '0;
    end else if (wr_en) begin
      rf[RDW[RAW-1:0]] <= ResultW;
    end
  end

  // Slot control: advance, load-use hazard, load/clear decisions
  logic adv;
  logic haz;
  logic load;
  logic clear;
  logic bubble;

  assign adv    = !ValidE || ReadyE;
  assign haz    = ValidE && ResultSrcE && (RD_E != 5'd0) &&
                  (RD_E == rs1_d || RD_E == rs2_d);
  assign load   = !FlushE && adv && !haz && ValidD && !Halted;
  assign clear  = FlushE || (adv && !load);
  assign bubble = !FlushE && adv && haz;
  assign ReadyD = FlushE || (adv && !haz && !Halted);

  // ID/EX register; controls drop to 0 whenever the slot empties
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ValidE      <= 1'b0;
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= 3'b000;
      IllegalOp   <= 1'b0;
      RD1_E       <= '0;
      RD2_E       <= '0;
      ImmExt_E    <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      RD_E        <= 5'd0;
      RS1_E       <= 5'd0;
      RS2_E       <= 5'd0;
    end else if (load) begin
      ValidE      <= 1'b1;
      RegWriteE   <= reg_write_d;
      ALUSrcE     <= alu_src_d;
      MemWriteE   <= mem_write_d;
      ResultSrcE  <= result_src_d;
      BranchE     <= branch_d;
      ALUControlE <= alu_control_d;
      IllegalOp   <= illegal_d;
      RD1_E       <= rd1_d;
      RD2_E       <= rd2_d;
      ImmExt_E    <= imm_ext_d;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      RD_E        <= rd_d;
      RS1_E       <= rs1_d;
      RS2_E       <= rs2_d;
    end else if (clear) begin
      ValidE      <= 1'b0;
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= 3'b000;
      IllegalOp   <= 1'b0;
    end
  end

  // Sticky halt once an illegal instruction is handed to execute
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Halted <= 1'b0;
    end else if (ValidE && IllegalOp && ReadyE) begin
      Halted <= 1'b1;
    end
  end

`ifdef DECODE_STALL_COUNT_EN
  // Saturating count of inserted load-use bubbles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      StallCnt <= 32'd0;
    end else if (bubble && StallCnt != 32'hFFFF_FFFF) begin
      StallCnt <= StallCnt + 32'd1;
    end
  end
`else
  assign StallCnt = 32'd0;
  logic unused_bubble;
  assign unused_bubble = bubble;
`endif

endmodule

// File: tb/tb_decode_stage_hs.sv
// Bench for decode_stage_hs: an RV32I (NREGS=32) and an RV32E (NREGS=16)
// instance share one stimulus stream; both are compared every cycle with a
// reference model built from the instruction-set rules.
module tb_decode_stage_hs;

  logic        clk;
  logic        rst;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        FlushE;
  logic        ReadyE;

  logic        ready_d      [2];
  logic        valid_e      [2];
  logic        reg_write_e  [2];
  logic        alu_src_e    [2];
  logic        mem_write_e  [2];
  logic        result_src_e [2];
  logic        branch_e     [2];
  logic [2:0]  alu_control_e[2];
  logic [31:0] rd1_e        [2];
  logic [31:0] rd2_e        [2];
  logic [31:0] imm_ext_e    [2];
  logic [31:0] pc_e         [2];
  logic [31:0] pc_plus4_e   [2];
  logic [4:0]  rd_e         [2];
  logic [4:0]  rs1_e        [2];
  logic [4:0]  rs2_e        [2];
  logic        illegal_op   [2];
  logic        halted       [2];
  logic [31:0] stall_cnt    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    decode_stage_hs #(
      .XLEN(32), .NREGS((g == 0) ? 32 : 16), .RF_BYPASS(1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .ValidD(ValidD), .ReadyD(ready_d[g]), .InstrD(InstrD),
      .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
      .FlushE(FlushE), .ValidE(valid_e[g]), .ReadyE(ReadyE),
      .RegWriteE(reg_write_e[g]), .ALUSrcE(alu_src_e[g]),
      .MemWriteE(mem_write_e[g]), .ResultSrcE(result_src_e[g]),
      .BranchE(branch_e[g]), .ALUControlE(alu_control_e[g]),
      .RD1_E(rd1_e[g]), .RD2_E(rd2_e[g]), .ImmExt_E(imm_ext_e[g]),
      .PCE(pc_e[g]), .PCPlus4E(pc_plus4_e[g]),
      .RD_E(rd_e[g]), .RS1_E(rs1_e[g]), .RS2_E(rs2_e[g]),
      .IllegalOp(illegal_op[g]), .Halted(halted[g]), .StallCnt(stall_cnt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        valid, rw, alusrc, mw, rsrc, br, ill;
    logic [2:0]  aluc;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rd, rs1, rs2;
  } slot_t;

  slot_t       ms     [2];
  logic        mh     [2];
  logic [31:0] mstall [2];
  logic [31:0] mrf    [2][32];
  logic        rdy_seen [2];

  function automatic int nr_of(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  // ALU operation codes: add 000, sub 001, and 010, or 011, slt 101
  function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic slot_t decode_ref(input logic [31:0] ins, input int nr);
    slot_t s;
    bit u1, u2, ud;
    s     = '0;
    s.rd  = ins[11:7];
    s.rs1 = ins[19:15];
    s.rs2 = ins[24:20];
    // register-register and unknown opcodes carry the I-format immediate
    s.imm = 32'($signed(ins[31:20]));
    u1 = 0; u2 = 0; ud = 0;
    case (ins[6:0])
      7'b0000011: begin s.rw = 1; s.alusrc = 1; s.rsrc = 1; u1 = 1; ud = 1; end
      7'b0100011: begin
        s.alusrc = 1; s.mw = 1; u1 = 1; u2 = 1;
        s.imm = 32'($signed({ins[31:25], ins[11:7]}));
      end
      7'b0110011: begin
        s.rw = 1; s.aluc = alu_ref(ins[14:12], ins[30]); u1 = 1; u2 = 1; ud = 1;
      end
      7'b0010011: begin
        s.rw = 1; s.alusrc = 1; s.aluc = alu_ref(ins[14:12], 1'b0); u1 = 1; ud = 1;
      end
      7'b1100011: begin
        s.br = 1; s.aluc = 3'b001; u1 = 1; u2 = 1;
        s.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      default: s.ill = 1;
    endcase
    if (nr == 16 && ((u1 && s.rs1 >= 16) || (u2 && s.rs2 >= 16) || (ud && s.rd >= 16)))
      s.ill = 1;
    s.valid = 1;
    return s;
  endfunction

  function automatic slot_t kill(input slot_t s);
    slot_t r;
    r = s;
    r.valid = 0; r.rw = 0; r.alusrc = 0; r.mw = 0; r.rsrc = 0; r.br = 0; r.ill = 0;
    r.aluc = 3'b000;
    return r;
  endfunction

  function automatic logic [31:0] m_read(input int k, input logic [4:0] idx);
    if (idx == 0 || int'(idx) >= nr_of(k)) return 32'd0;
    if (RegWriteW && RDW == idx) return ResultW;
    return mrf[k][idx];
  endfunction

  function automatic logic m_haz(input int k);
    return ms[k].valid && ms[k].rsrc && ms[k].rd != 0 &&
           (ms[k].rd == InstrD[19:15] || ms[k].rd == InstrD[24:20]);
  endfunction

  function automatic logic m_ready(input int k);
    logic adv;
    adv = !ms[k].valid || ReadyE;
    return FlushE || (adv && !m_haz(k) && !mh[k]);
  endfunction

  task automatic model_step(input int k);
    slot_t cur, nxt;
    logic  adv, haz;
    cur = ms[k];
    adv = !cur.valid || ReadyE;
    haz = m_haz(k);
    nxt = cur;
    if (FlushE) nxt = kill(cur);
    else if (adv && haz) begin
      nxt = kill(cur);
`ifdef DECODE_STALL_COUNT_EN
      if (mstall[k] != 32'hFFFF_FFFF) mstall[k] = mstall[k] + 1;
`endif
    end else if (adv && ValidD && !mh[k]) begin
      nxt     = decode_ref(InstrD, nr_of(k));
      nxt.rd1 = m_read(k, InstrD[19:15]);
      nxt.rd2 = m_read(k, InstrD[24:20]);
      nxt.pc  = PCD;
      nxt.pc4 = PCPlus4D;
    end else if (adv) nxt = kill(cur);
    if (cur.valid && cur.ill && ReadyE) mh[k] = 1;
    ms[k] = nxt;
    if (RegWriteW && RDW != 0 && int'(RDW) < nr_of(k)) mrf[k][RDW] = ResultW;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k] = '0; mh[k] = 0; mstall[k] = 0;
      for (int r = 0; r < 32; r++) mrf[k][r] = 0;
    end
  endtask

  task automatic check_outputs(input bit all_data);
    for (int k = 0; k < 2; k++) begin
      string p;
      p = (k == 0) ? "rv32i" : "rv32e";
      check({p, ".valid_e"},    32'(valid_e[k]),       32'(ms[k].valid));
      check({p, ".reg_write"},  32'(reg_write_e[k]),   32'(ms[k].rw));
      check({p, ".alu_src"},    32'(alu_src_e[k]),     32'(ms[k].alusrc));
      check({p, ".mem_write"},  32'(mem_write_e[k]),   32'(ms[k].mw));
      check({p, ".result_src"}, 32'(result_src_e[k]),  32'(ms[k].rsrc));
      check({p, ".branch"},     32'(branch_e[k]),      32'(ms[k].br));
      check({p, ".alu_ctrl"},   32'(alu_control_e[k]), 32'(ms[k].aluc));
      check({p, ".illegal"},    32'(illegal_op[k]),    32'(ms[k].ill));
      check({p, ".halted"},     32'(halted[k]),        32'(mh[k]));
      check({p, ".stall_cnt"},  stall_cnt[k],          mstall[k]);
      if (all_data || ms[k].valid) begin
        check({p, ".rd1"},    rd1_e[k],      ms[k].rd1);
        check({p, ".rd2"},    rd2_e[k],      ms[k].rd2);
        check({p, ".imm"},    imm_ext_e[k],  ms[k].imm);
        check({p, ".pc"},     pc_e[k],       ms[k].pc);
        check({p, ".pc4"},    pc_plus4_e[k], ms[k].pc4);
        check({p, ".rd"},     32'(rd_e[k]),  32'(ms[k].rd));
        check({p, ".rs1"},    32'(rs1_e[k]), 32'(ms[k].rs1));
        check({p, ".rs2"},    32'(rs2_e[k]), 32'(ms[k].rs2));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic apply(input logic vd, input logic [31:0] ins, input logic rw,
                       input logic [4:0] rdw, input logic [31:0] res,
                       input logic fl, input logic re);
    @(negedge clk);
    ValidD = vd; InstrD = ins; RegWriteW = rw; RDW = rdw; ResultW = res;
    FlushE = fl; ReadyE = re;
    PCD = $urandom; PCPlus4D = PCD + 32'd4;
    #1;
    for (int k = 0; k < 2; k++) begin
      rdy_seen[k] = ready_d[k];
      check((k == 0) ? "rv32i.ready_d" : "rv32e.ready_d", 32'(ready_d[k]), 32'(m_ready(k)));
    end
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk);
    #1;
    check_outputs(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ValidD = 0; RegWriteW = 0; FlushE = 0; ReadyE = 1;
    rst = 0;
    #1;
    model_reset();
    check_outputs(1'b1);
    @(negedge clk);
    rst = 1;
  endtask

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(0, 39) == 0) return 5'($urandom_range(16, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] x;
    rd = rnd_reg(); r1 = rnd_reg(); r2 = rnd_reg();
    case ($urandom_range(0, 4))
      0: f3 = 3'b000;
      1: f3 = 3'b010;
      2: f3 = 3'b110;
      3: f3 = 3'b111;
      default: f3 = 3'($urandom);
    endcase
    imm = 12'($urandom);
    x   = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 8: return {imm, r1, 3'b010, rd, 7'b0000011};
      2:       return {imm[11:5], r2, r1, 3'b010, imm[4:0], 7'b0100011};
      3, 4:    return {1'b0, x[0], 5'b0, r2, r1, f3, rd, 7'b0110011};
      5, 6:    return {imm, r1, f3, rd, 7'b0010011};
      7:       return {imm[11:5], r2, r1, 3'b000, imm[4:0], 7'b1100011};
      default: begin
        if ($urandom_range(0, 4) == 0) return {x[31:7], 7'b1110111};
        return {imm, r1, f3, rd, 7'b0010011};
      end
    endcase
  endfunction

  localparam logic [31:0] I_ADDI_X1 = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADD_X4  = 32'h0031_8233; // add  x4,x3,x3
  localparam logic [31:0] I_LW_X5   = 32'h0001_2283; // lw   x5,0(x2)
  localparam logic [31:0] I_ADD_X6  = 32'h0012_8333; // add  x6,x5,x1
  localparam logic [31:0] I_ADD_X17 = 32'h0020_88B3; // add  x17,x1,x2

  initial begin
    logic [31:0] exp_stall;
    rst = 0; ValidD = 0; InstrD = 0; PCD = 0; PCPlus4D = 0;
    RegWriteW = 0; RDW = 0; ResultW = 0; FlushE = 0; ReadyE = 1;
    model_reset();

    // addi loads into the slot one edge after acceptance
    do_reset();
    apply(1, I_ADDI_X1, 0, 0, 0, 0, 1);
    check("addi.ready_d", 32'(rdy_seen[0]), 32'd1);
    check("addi.valid_e", 32'(valid_e[0]), 32'd1);
    check("addi.reg_write", 32'(reg_write_e[0]), 32'd1);
    check("addi.alu_src", 32'(alu_src_e[0]), 32'd1);
    check("addi.imm", imm_ext_e[0], 32'd5);
    check("addi.rd", 32'(rd_e[0]), 32'd1);

    // same-cycle writeback is forwarded to both operands
    apply(1, I_ADD_X4, 1, 5'd3, 32'hDEAD_BEEF, 0, 1);
    check("byp.rd1", rd1_e[0], 32'hDEAD_BEEF);
    check("byp.rd2", rd2_e[0], 32'hDEAD_BEEF);
    check("byp.rd1_e", rd1_e[1], 32'hDEAD_BEEF);

    // load-use: exactly one bubble, then the dependent add loads
    do_reset();
    apply(1, I_LW_X5, 0, 0, 0, 0, 1);
    apply(1, I_ADD_X6, 0, 0, 0, 0, 1);
    check("lu.ready_stall", 32'(rdy_seen[0]), 32'd0);
    check("lu.bubble", 32'(valid_e[0]), 32'd0);
    apply(1, I_ADD_X6, 0, 0, 0, 0, 1);
    check("lu.ready_go", 32'(rdy_seen[0]), 32'd1);
    check("lu.valid", 32'(valid_e[0]), 32'd1);
    check("lu.rd", 32'(rd_e[0]), 32'd6);
`ifdef DECODE_STALL_COUNT_EN
    exp_stall = 32'd1;
`else
    exp_stall = 32'd0;
`endif
    check("lu.stall_cnt", stall_cnt[0], exp_stall);

    // execute back-pressure holds the slot and blocks decode
    do_reset();
    apply(1, I_ADDI_X1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      apply(1, I_ADD_X6, 0, 0, 0, 0, 0);
      check("bp.ready_d", 32'(rdy_seen[0]), 32'd0);
      check("bp.rd_held", 32'(rd_e[0]), 32'd1);
    end
    apply(1, I_ADD_X6, 0, 0, 0, 0, 1);
    check("bp.release_rd", 32'(rd_e[0]), 32'd6);

    // flush kills the slot and the D beat, which is not replayed
    do_reset();
    apply(1, I_ADDI_X1, 0, 0, 0, 0, 1);
    apply(1, I_LW_X5, 0, 0, 0, 1, 0);
    check("fl.ready_d", 32'(rdy_seen[0]), 32'd1);
    check("fl.valid", 32'(valid_e[0]), 32'd0);
    check("fl.reg_write", 32'(reg_write_e[0]), 32'd0);
    apply(0, I_LW_X5, 0, 0, 0, 0, 1);
    check("fl.no_replay", 32'(valid_e[0]), 32'd0);

    // RV32E: x17 is illegal, halts once accepted by execute
    do_reset();
    apply(1, I_ADD_X17, 0, 0, 0, 0, 1);
    check("e.illegal", 32'(illegal_op[1]), 32'd1);
    check("i.legal", 32'(illegal_op[0]), 32'd0);
    apply(0, 32'd0, 0, 0, 0, 0, 1);
    check("e.halted", 32'(halted[1]), 32'd1);
    apply(1, I_ADDI_X1, 0, 0, 0, 0, 1);
    check("e.halt_ready", 32'(rdy_seen[1]), 32'd0);
    check("e.halt_valid", 32'(valid_e[1]), 32'd0);
    do_reset();
    check("e.unhalted", 32'(halted[1]), 32'd0);

    // randomized traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      apply($urandom_range(0, 9) < 8, rnd_instr(), 1'($urandom_range(0, 1)),
            rnd_reg(), $urandom, $urandom_range(0, 11) == 0,
            $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/decode_stage_hs.md
Name: decode_stage_hs

Overview:
- Parametrised decode stage plus ID/EX pipeline register for the RV32I/RV32E pipeline core.
- Decodes InstrD through the existing Control_Unit_Top and Sign_Extend.
- Holds an internal NREGS-entry register file with write-through bypass.
- Adds what the first-generation stage lacks: valid/ready handshakes on both sides, branch flush, load-use interlock with bubble insertion, and a sticky illegal-instruction halt.

Parameters:
- XLEN, 32, datapath width of register file, PC and immediate.
- NREGS, 32, architectural register count; legal values 32 (RV32I) and 16 (RV32E).
- RF_BYPASS, 1, 1 = same-cycle writeback-to-read forwarding in the register file; 0 = read old value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- ValidD  in  1  decode-side instruction valid.
- ReadyD  out  1  decode stage accepts the beat this cycle.
- InstrD  in  32  instruction.
- PCD  in  XLEN  PC of instruction.
- PCPlus4D  in  XLEN  PC+4.
- RegWriteW  in  1  writeback enable.
- RDW  in  5  writeback register index.
- ResultW  in  XLEN  writeback data.
- FlushE  in  1  taken branch: kill the ID/EX slot and the current D beat.
- ValidE  out  1  execute-side slot valid.
- ReadyE  in  1  execute accepts the slot.
- RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  out  1 each  registered controls.
- ALUControlE  out  3  registered ALU op.
- RD1_E, RD2_E, ImmExt_E, PCE, PCPlus4E  out  XLEN  registered operands and PCs.
- RD_E, RS1_E, RS2_E  out  5  registered register indices.
- IllegalOp  out  1  registered illegal flag of the slot.
- Halted  out  1  sticky halt after an illegal instruction reaches E.
- StallCnt  out  32  load-use stall cycle count (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - All registered outputs, Halted and StallCnt go to 0; register file cleared.
  - ReadyD = 1 once out of reset.
- Slot advance: adv = !ValidE || ReadyE.
- Hazard:
  - haz = ValidE && ResultSrcE && RD_E!=0 && (RD_E==InstrD[19:15] || RD_E==InstrD[24:20]).
  - Compare rs2 even for I-type; the conservative stall is accepted.
- ReadyD = adv && !haz && !Halted, or 1 when FlushE.
- Each rising clk edge, in priority order:
  - FlushE: ValidE←0 and all control outputs←0; the D beat is consumed and discarded.
  - else if adv && haz: bubble. ValidE←0, controls←0, D is held (ReadyD=0). One bubble per load-use pair.
  - else if adv && ValidD && !Halted: load all E registers from the decode of InstrD; ValidE←1.
  - else if adv: ValidE←0, controls←0.
  - else (!adv): hold everything.
- Data regs (RD1_E etc.) may keep stale values in bubbles; control outputs must be 0 whenever ValidE=0.
- Latency: 1 cycle from accepted D beat to ValidE.
- Register file:
  - x0 reads 0 and ignores writes.
  - A write happens on the edge when RegWriteW && RDW!=0 && RDW<NREGS.
  - Writes with RDW>=NREGS are dropped.
  - With RF_BYPASS=1, a read of the index being written returns ResultW the same cycle.
- IllegalOp_D = control-unit IllegalOp, OR (NREGS==16 and any of rs1/rs2/rd bit 4 is set) for formats using that field.
- Halted←1 on the edge where ValidE && IllegalOp && ReadyE; it clears only by reset.
- Reset mid-stall or mid-flush returns the block to the empty state.
- Simultaneous FlushE and haz: flush wins; no stall is counted.

Optional Feature:
- Macro DECODE_STALL_COUNT_EN.
- Defined: StallCnt increments by 1 on every edge where a hazard bubble is inserted; it saturates at 0xFFFFFFFF.
- Undefined: StallCnt is tied to 0 and no counter is synthesised.

Test Plan:
- Reset, then feed `addi x1,x0,5` (0x00500093) with ValidD=1, ReadyE=1 → next edge: ValidE=1, RegWriteE=1, ALUSrcE=1, ImmExt_E=5, RD_E=1.
- Writeback x3=0xDEAD_BEEF while decoding `add x4,x3,x3` in the same cycle, RF_BYPASS=1 → RD1_E=RD2_E=0xDEADBEEF.
- `lw x5,0(x2)` followed by `add x6,x5,x1`:
  - ReadyD=0 for exactly 1 cycle and one bubble with ValidE=0.
  - add appears the next cycle.
  - StallCnt=1 with macro defined, 0 without.
- Hold ReadyE=0 for 3 cycles with ValidE=1 → all E outputs stable, ReadyD=0; release → next beat loads.
- Assert FlushE with a valid D beat and a valid slot → next edge ValidE=0, RegWriteE=MemWriteE=BranchE=0; the D beat is not replayed.
- NREGS=16, `add x17,x1,x2` → IllegalOp=1 in E; after ReadyE, Halted=1 and ReadyD=0 until rst pulses low.
